niosiisystem_pll_lock_supervisor: RTL
=====================================

Name: niosiisystem_pll_lock_supervisor

Overview:
Supervises the SDRAM/system PLL from the control side. It drives the PLL reset, consumes the PLL lock indication and holds the system reset until lock has been stable. It re-cycles the PLL on lock timeout or lock loss, and counts lock-loss events for software status. It runs on the free-running 50 MHz reference clock, never on a PLL output.

Parameters:
SYNC_STAGES, 2, synchronizer depth for pll_locked (min 2)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (min 1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before system reset release (min 1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before the PLL is reset again (min 2)
MAX_RETRIES, 7, consecutive timeouts before entering FAULT (min 1)

Ports:
clk  in  1  reference clock (same source as PLL refclk)
reset_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to clk
clear_fault  in  1  synchronous pulse; leaves FAULT
pll_rst  out  1  active-high PLL reset
sys_reset_n  out  1  active-low reset to PLL-clocked logic
fault  out  1  PLL failed to lock MAX_RETRIES times in a row
lock_loss_count  out  8  saturating count of lock losses while in RUN
state  out  3  encoding: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n=0 the block holds: state=PLL_RST, pll_rst=1, sys_reset_n=0, fault=0, lock_loss_count=0, retry and cycle counters 0, synchronizer flops 0.
- All outputs are Moore outputs taken directly from flops, so they change on the same edge as state:
  - pll_rst=1 iff state=PLL_RST
  - sys_reset_n=1 iff state=RUN
  - fault=1 iff state=FAULT
- pll_locked passes through a SYNC_STAGES flop chain to give locked_s. Only locked_s is used.
- One cycle counter, width clog2 of the largest count parameter. It is cleared on every state transition.
- PLL_RST: the counter counts 0..PLL_RST_CYCLES-1. On the edge where it equals PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Otherwise, when the counter equals LOCK_TIMEOUT_CYCLES-1: if retry+1 == MAX_RETRIES go to FAULT; otherwise retry++ and go to PLL_RST.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK. This is a glitch: no retry increment and no lock_loss_count increment. The WAIT_LOCK timeout restarts.
  - If locked_s=1 and the counter equals LOCK_STABLE_CYCLES-1, go to RUN and clear retry.
- RUN:
  - If locked_s=0, go to PLL_RST, and lock_loss_count increments, saturating at 255. sys_reset_n falls on that edge.
- FAULT:
  - Held until clear_fault=1. Then go to PLL_RST and clear retry. lock_loss_count is preserved.
  - clear_fault is ignored in every other state.
- Latency:
  - First edge sampling pll_locked=1 is edge 1. locked_s=1 after edge SYNC_STAGES. STABLE is entered at edge SYNC_STAGES+1. sys_reset_n rises at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES.
  - Lock loss in RUN: sys_reset_n falls SYNC_STAGES+1 edges after pll_locked falls.
- Simultaneous events:
  - A timeout and a lock on the same edge in WAIT_LOCK: lock wins, go to STABLE.
  - Lock loss on the edge the STABLE count completes: go to WAIT_LOCK.
- Reset mid-operation: any state returns immediately to PLL_RST with the reset values above.
- Unreachable state encodings recover to PLL_RST on the next edge.

Test Plan:
Bench parameters for all cases: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=16, MAX_RETRIES=3.
1. Release reset_n; raise pll_locked 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_reset_n rises at edge 11 counted from the first edge sampling lock; state sequence 0,1,2,3.
2. In STABLE at count 5, drop pll_locked for 1 cycle -> state returns to 1 then 2; sys_reset_n is delayed by a full fresh 8-cycle window; lock_loss_count stays 0.
3. In RUN, drop pll_locked -> sys_reset_n=0 and pll_rst=1 on edge 3; pll_rst high 4 cycles; lock_loss_count=1; relock -> RUN again.
4. Keep pll_locked=0 -> three 4+16-cycle attempts; fault=1 and state=4 at cycle 60 after reset release; pulse clear_fault -> state=0, fault=0, pll_rst=1.
5. Assert reset_n asynchronously mid-RUN (between clock edges) -> pll_rst=1, sys_reset_n=0 and lock_loss_count=0 without waiting for an edge.
6. Run 260 lock-loss/relock cycles -> lock_loss_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/niosiisystem_pll_lock_supervisor.sv
// PLL lock supervisor on the free-running reference clock: drives pll_rst, qualifies lock,
// releases sys_reset_n after stable lock, retries on timeout/loss, and faults after repeated timeouts.
module niosiisystem_pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] C_RTY_LAST = RTY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [RTY_W-1:0]       r_retry;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pll_rst;
  logic                   r_sys_reset_n;
  logic                   r_fault;
  logic [7:0]             r_loss;
  logic                   w_locked_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // Every transition clears the cycle counter; outputs are set alongside the state they decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_PLL_RST;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_fault       <= 1'b0;
      r_loss        <= '0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == C_RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_TO_LAST) begin
            r_cnt <= '0;
            if (r_retry == C_RTY_LAST) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_retry   <= r_retry + 1'b1;
              r_state   <= S_PLL_RST;
              r_pll_rst <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STB_LAST) begin
            r_state       <= S_RUN;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_sys_reset_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= '0;
          if (!w_locked_s) begin
            r_state       <= S_PLL_RST;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            if (r_loss != 8'hFF) begin
              r_loss <= r_loss + 8'd1;
            end
          end
        end
        S_FAULT: begin
          r_cnt <= '0;
          if (clear_fault) begin
            r_state   <= S_PLL_RST;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_fault   <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_PLL_RST;
          r_cnt         <= '0;
          r_retry       <= '0;
          r_pll_rst     <= 1'b1;
          r_sys_reset_n <= 1'b0;
          r_fault       <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst         = r_pll_rst;
  assign sys_reset_n     = r_sys_reset_n;
  assign fault           = r_fault;
  assign lock_loss_count = r_loss;
  assign state           = r_state;

endmodule
